// File: rtl/seg_display_scanner_pkg.sv
// Shared scanner definitions: FSM state encodings and the all-segments-off pattern.
package seg_display_scanner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/scan_slot_timer.sv
// Loadable down-counter that times BLANK and DRIVE slots; tc_c flags the last cycle of a slot.
module scan_slot_timer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reload,
   input  logic [WIDTH-1:0] reload_val,
   output logic             tc_c
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (reload) begin
         cnt <= reload_val;
      end else if (cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign tc_c = (cnt == '0);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 7-segment scanner sharing one decoder across NUM_DIGITS digits.
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading-zero digits dark.
module seg_display_scanner
   import seg_display_scanner_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   output logic [3:0]              dec_digit,
   output logic                    dec_enable,
   input  logic [6:0]              seg_in,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   an_n
);

   localparam int unsigned DIG_W    = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned MAX_SLOT = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int unsigned CNT_W    = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;

   scan_state_e             state, state_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [DIG_W-1:0]        shadow, active, active_nxt;
   logic                    reload;
   logic [CNT_W-1:0]        reload_val;
   logic                    tc_c;
   logic                    lead_blank;
   logic [NUM_DIGITS-1:0]   an_n_nxt;
   logic [3:0]              dec_digit_nxt;
   logic                    dec_enable_nxt;
   logic [6:0]              seg_out_nxt;

   scan_slot_timer #(.WIDTH(CNT_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .reload     (reload),
      .reload_val (reload_val),
      .tc_c       (tc_c)
   );

   // Next-state, slot index and frame-boundary copy of shadow into active.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      active_nxt = active;
      reload     = 1'b0;
      reload_val = '0;
      if (!enable) begin
         state_nxt = ST_IDLE;
         idx_nxt   = '0;
         reload    = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_nxt  = ST_BLANK;
               idx_nxt    = '0;
               active_nxt = shadow;
               reload     = 1'b1;
               reload_val = CNT_W'(BLANK_CYCLES - 1);
            end
            ST_BLANK: begin
               if (tc_c) begin
                  state_nxt  = ST_DRIVE;
                  reload     = 1'b1;
                  reload_val = CNT_W'(SCAN_DIV - 1);
               end
            end
            ST_DRIVE: begin
               if (tc_c) begin
                  state_nxt  = ST_BLANK;
                  idx_nxt    = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                  reload     = 1'b1;
                  reload_val = CNT_W'(BLANK_CYCLES - 1);
                  if (idx_nxt == '0) begin
                     active_nxt = shadow;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs are computed for the upcoming state so they register in step with it.
   always_comb begin
      an_n_nxt       = '1;
      dec_enable_nxt = (state_nxt != ST_IDLE);
      dec_digit_nxt  = dec_enable_nxt ? active_nxt[{idx_nxt, 2'b00} +: 4] : 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
      lead_blank     = (idx_nxt != '0) && ((active_nxt >> {idx_nxt, 2'b00}) == '0);
`else
      lead_blank     = 1'b0;
`endif
      if (state_nxt == ST_DRIVE && !lead_blank) begin
         an_n_nxt[idx_nxt] = 1'b0;
      end
      seg_out_nxt = (state != ST_IDLE && state_nxt != ST_IDLE) ? seg_in : SEG_OFF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         idx        <= '0;
         shadow     <= '0;
         active     <= '0;
         an_n       <= '1;
         dec_digit  <= 4'h0;
         dec_enable <= 1'b0;
         seg_out    <= SEG_OFF;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         active     <= active_nxt;
         an_n       <= an_n_nxt;
         dec_digit  <= dec_digit_nxt;
         dec_enable <= dec_enable_nxt;
         seg_out    <= seg_out_nxt;
         if (load) begin
            shadow <= digits_in;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner with a frame-position model and a bench-side decoder.
module tb_seg_display_scanner;

   localparam int N     = 4;
   localparam int S     = 4;
   localparam int B     = 2;
   localparam int SLOT  = B + S;
   localparam int FRAME = N * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digits_in = 16'h0000;
   logic [3:0]  dec_digit;
   logic        dec_enable;
   logic [6:0]  seg_in;
   logic [6:0]  seg_out;
   logic [3:0]  an_n;

   int vectors = 0;
   int miscompares = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   seg_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .digits_in  (digits_in),
      .dec_digit  (dec_digit),
      .dec_enable (dec_enable),
      .seg_in     (seg_in),
      .seg_out    (seg_out),
      .an_n       (an_n)
   );

   // Stand-in for bin_to_segments (gfedcba, active-high)
   function automatic logic [6:0] seg_lut(input logic [3:0] d);
      case (d)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   assign seg_in = dec_enable ? seg_lut(dec_digit) : 7'h00;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: whether scanning, position within the frame, and the two digit registers
   bit          mrun = 1'b0;
   int          mt = 0;
   logic [15:0] mshadow = 16'h0;
   logic [15:0] mactive = 16'h0;
   logic [6:0]  mseg = 7'h00;

   function automatic logic [3:0] m_dd();
      int slot;
      slot = mt / SLOT;
      return mrun ? mactive[slot*4 +: 4] : 4'h0;
   endfunction

   function automatic logic [3:0] m_an();
      int slot;
      logic [3:0] a;
      slot = mt / SLOT;
      a = 4'hF;
      if (mrun && (mt % SLOT) >= B) begin
`ifdef LEADING_ZERO_BLANK_EN
         if (!(slot != 0 && (mactive >> (slot * 4)) == 16'h0)) a[slot] = 1'b0;
`else
         a[slot] = 1'b0;
`endif
      end
      return a;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mrun <= 1'b0; mt <= 0; mshadow <= 16'h0; mactive <= 16'h0; mseg <= 7'h00;
      end else begin
         if (!enable) begin
            mrun <= 1'b0; mt <= 0;
         end else if (!mrun) begin
            mrun <= 1'b1; mt <= 0; mactive <= mshadow;
         end else begin
            mt <= (mt + 1) % FRAME;
            if ((mt + 1) % FRAME == 0) mactive <= mshadow;
         end
         if (load) mshadow <= digits_in;
         mseg <= (enable && mrun) ? seg_lut(m_dd()) : 7'h00;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_an_n", 16'(an_n), 16'(m_an()));
         chk("model_dec_digit", 16'(dec_digit), 16'(m_dd()));
         chk("model_dec_enable", 16'(dec_enable), 16'(mrun));
         chk("model_seg_out", 16'(seg_out), 16'(mseg));
      end
   end

   logic [3:0] exp_an [12] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD};
   logic [3:0] exp_dd [12] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3};

   task automatic mask_test(input string name, input logic [15:0] v, input logic [3:0] exp_mask);
      logic [3:0] mask;
      @(negedge clk); load = 1'b1; digits_in = v;
      @(negedge clk); load = 1'b0;
      repeat (FRAME) @(negedge clk);
      mask = 4'h0;
      repeat (FRAME) begin
         @(negedge clk);
         mask = mask | ~an_n;
      end
      chk(name, 16'(mask), 16'(exp_mask));
   endtask

   initial begin
      int guard;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_an_n", 16'(an_n), 16'h000F);
      chk("reset_seg_out", 16'(seg_out), 16'h0000);
      chk("reset_dec_enable", 16'(dec_enable), 16'h0000);
      chk("reset_dec_digit", 16'(dec_digit), 16'h0000);
      cmp_on = 1'b1;
      #3 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_an_n", 16'(an_n), 16'h000F);

      load = 1'b1; digits_in = 16'h1234;
      @(negedge clk); load = 1'b0; enable = 1'b1;
      for (int k = 0; k < 96; k++) begin
         @(negedge clk);
         load = 1'b0;
         if (k < 12) begin
            chk("first_frame_an_n", 16'(an_n), 16'(exp_an[k]));
            chk("first_frame_dec_digit", 16'(dec_digit), 16'(exp_dd[k]));
         end
         if (k == 0) chk("first_blank_seg_off", 16'(seg_out), 16'h0000);
         if (k == 2) chk("digit0_seg_pattern4", 16'(seg_out), 16'h0066);
         if (k == 7) chk("digit1_seg_pattern3", 16'(seg_out), 16'h004F);
         if (k == 14) chk("idx2_drive_an_n", 16'(an_n), 16'h000B);
         if (k == 16) chk("no_tearing_old_digit", 16'(dec_digit), 16'h0002);
         if (k == 24) chk("next_frame_new_digit", 16'(dec_digit), 16'h0008);
         if (k == 48) chk("boundary_load_deferred", 16'(dec_digit), 16'h0008);
         if (k == 72) chk("boundary_load_applied", 16'(dec_digit), 16'h000C);
         if (k == 88) begin
            chk("disable_an_n", 16'(an_n), 16'h000F);
            chk("disable_seg_out", 16'(seg_out), 16'h0000);
            chk("disable_dec_enable", 16'(dec_enable), 16'h0000);
         end
         if (k == 91) chk("reenable_idx0_blank", 16'({an_n, dec_digit}), 16'h00FC);
         if (k == 93) chk("reenable_idx0_drive", 16'({an_n, 1'b0, seg_out}), 16'h0E39);
         if (k == 11) begin load = 1'b1; digits_in = 16'h5678; end
         if (k == 47) begin load = 1'b1; digits_in = 16'h9ABC; end
         if (k == 87) enable = 1'b0;
         if (k == 90) enable = 1'b1;
      end

`ifdef LEADING_ZERO_BLANK_EN
      mask_test("lead_zero_0007", 16'h0007, 4'h1);
      mask_test("lead_zero_0000", 16'h0000, 4'h1);
      mask_test("lead_zero_0507", 16'h0507, 4'h7);
`else
      mask_test("all_digits_0007", 16'h0007, 4'hF);
      mask_test("all_digits_0000", 16'h0000, 4'hF);
      mask_test("all_digits_0507", 16'h0507, 4'hF);
`endif

      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (an_n == 4'hF && guard < 100);
      if (guard >= 100) begin
         vectors++;
         miscompares++;
         $display("FAIL drive_wait: got no anode low expected one within 100 cycles");
      end
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_an_n", 16'(an_n), 16'h000F);
      chk("async_reset_seg_out", 16'(seg_out), 16'h0000);
      chk("async_reset_dec", 16'({dec_enable, dec_digit}), 16'h0000);
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("restart_blank", 16'({dec_enable, an_n, dec_digit}), 16'h01F0);
      repeat (2) @(negedge clk);
      chk("restart_idx0_drive", 16'(an_n), 16'h000E);
      repeat (30) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
